// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle between the CPU datapath and the pipe_ctrl sequencer.
// master: the sequencer (samples pipeline status, drives npc/stall/flush/perf).
// slave : the datapath side (drives pipeline status, consumes control).
interface pipe_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      pc;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_rs1_re;
  logic             id_rs2_re;
  logic             id_jump;
  logic [31:0]      id_jump_tgt;
  logic [4:0]       ex_rd;
  logic             ex_mem_read;
  logic             ex_br_taken;
  logic [31:0]      ex_br_tgt;
  logic             mem_req;
  logic             mem_ack;
  logic [31:0]      npc;
  logic             stall_pc;
  logic             stall_if_id;
  logic             stall_id_ex;
  logic             stall_ex_mem;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic [CNT_W-1:0] perf_stall;
  logic [CNT_W-1:0] perf_flush;

  modport master (
    input  pc, id_rs1, id_rs2, id_rs1_re, id_rs2_re, id_jump, id_jump_tgt,
    input  ex_rd, ex_mem_read, ex_br_taken, ex_br_tgt, mem_req, mem_ack,
    output npc, stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
    output flush_if_id, flush_id_ex, perf_stall, perf_flush
  );

  modport slave (
    output pc, id_rs1, id_rs2, id_rs1_re, id_rs2_re, id_jump, id_jump_tgt,
    output ex_rd, ex_mem_read, ex_br_taken, ex_br_tgt, mem_req, mem_ack,
    input  npc, stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
    input  flush_if_id, flush_id_ex, perf_stall, perf_flush
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: next-PC and stall/flush sequencer for the 5-stage CPU.
// Handles load-use bubbles, EX branch / ID jump redirects and data-memory waits.
// All control outputs are combinational from state + inputs; only the FSM state,
// the load-use bubble counter and the optional perf counters are registered.
// Optional feature macro: PIPE_CTRL_PERF_EN enables the saturating stall/redirect
// counters; without it perf_stall/perf_flush are constant zero and no flops exist.
module pipe_ctrl #(
  parameter int LU_CYCLES = 1,  // bubbles per load-use hazard, 1..3
  parameter int CNT_W     = 32
) (
  input  logic          clk,
  input  logic          rst,    // synchronous, active-low
  pipe_ctrl_if.master   bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  // Bubbles still owed after the first hazard cycle.
  localparam logic [1:0] LU_INIT = 2'(LU_CYCLES - 1);

  state_t      state_q, state_d, eff_state;
  logic [1:0]  lu_cnt_q, lu_cnt_d;

  logic        hazard;
  logic        mem_wait;
  logic [31:0] pc_inc;
  logic [31:0] npc_raw;
  logic        stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
  logic        flush_if_id, flush_id_ex;

  assign hazard = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                  ((bus.id_rs1_re && (bus.id_rs1 == bus.ex_rd)) ||
                   (bus.id_rs2_re && (bus.id_rs2 == bus.ex_rd)));

  assign mem_wait = bus.mem_req && !bus.mem_ack;
  assign pc_inc   = bus.pc + 32'd4;

  // Next-state and control outputs; mem_wait outranks everything, and once the
  // wait ends the controller behaves as the state it was interrupted from.
  always_comb begin
    state_d      = state_q;
    lu_cnt_d     = lu_cnt_q;
    npc_raw      = pc_inc;
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    stall_id_ex  = 1'b0;
    stall_ex_mem = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;

    eff_state = state_q;
    if (state_q == MEM_WAIT) begin
      eff_state = (lu_cnt_q != 2'd0) ? LU_STALL : RUN;
    end

    if (!rst) begin
      npc_raw     = 32'h0;
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
      state_d     = RUN;
      lu_cnt_d    = 2'd0;
    end else if (mem_wait) begin
      // Freeze the whole front end; lu_cnt is kept so a pending bubble resumes.
      npc_raw      = bus.pc;
      stall_pc     = 1'b1;
      stall_if_id  = 1'b1;
      stall_id_ex  = 1'b1;
      stall_ex_mem = 1'b1;
      state_d      = MEM_WAIT;
    end else begin
      case (eff_state)
        LU_STALL: begin
          // EX already holds a bubble here, so a branch cannot be resolved.
          npc_raw     = bus.pc;
          stall_pc    = 1'b1;
          stall_if_id = 1'b1;
          flush_id_ex = 1'b1;
          if (lu_cnt_q <= 2'd1) begin
            lu_cnt_d = 2'd0;
            state_d  = RUN;
          end else begin
            lu_cnt_d = lu_cnt_q - 2'd1;
            state_d  = LU_STALL;
          end
        end
        default: begin
          state_d = RUN;
          if (bus.ex_br_taken) begin
            // Wrong-path ID/IF contents are discarded, hazards with them too.
            npc_raw     = bus.ex_br_tgt;
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
          end else if (hazard) begin
            npc_raw     = bus.pc;
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
            flush_id_ex = 1'b1;
            lu_cnt_d    = LU_INIT;
            state_d     = (LU_INIT != 2'd0) ? LU_STALL : RUN;
          end else if (bus.id_jump) begin
            npc_raw     = bus.id_jump_tgt;
            flush_if_id = 1'b1;
          end else begin
            npc_raw = pc_inc;
          end
        end
      endcase
    end
  end

  // FSM state and bubble counter register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= RUN;
      lu_cnt_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      lu_cnt_q <= lu_cnt_d;
    end
  end

  assign bus.npc          = {npc_raw[31:2], 2'b00};
  assign bus.stall_pc     = stall_pc;
  assign bus.stall_if_id  = stall_if_id;
  assign bus.stall_id_ex  = stall_id_ex;
  assign bus.stall_ex_mem = stall_ex_mem;
  assign bus.flush_if_id  = flush_if_id;
  assign bus.flush_id_ex  = flush_id_ex;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] perf_stall_q, perf_flush_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Saturating counters of stalled-PC cycles and redirect cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (stall_pc) begin
        perf_stall_q <= sat_inc(perf_stall_q);
      end
      if (flush_if_id) begin
        perf_flush_q <= sat_inc(perf_flush_q);
      end
    end
  end

  assign bus.perf_stall = perf_stall_q;
  assign bus.perf_flush = perf_flush_q;
`else
  assign bus.perf_stall = {CNT_W{1'b0}};
  assign bus.perf_flush = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: two instances (LU_CYCLES=1 and 2) driven with
// directed per-cycle vectors; the expected outputs of each vector are queued and
// a negedge monitor pops and compares them.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(32)) if1 ();
  pipe_ctrl_if #(.CNT_W(32)) if2 ();

  pipe_ctrl #(.LU_CYCLES(1), .CNT_W(32)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.master));
  pipe_ctrl #(.LU_CYCLES(2), .CNT_W(32)) u_dut2 (.clk(clk), .rst(rst), .bus(if2.master));

  typedef struct {
    int          d;
    logic        r;
    logic [31:0] npc;
    logic [3:0]  st;   // {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem}
    logic [1:0]  fl;   // {flush_if_id, flush_id_ex}
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] mdl_ps [1:2];
  logic [31:0] mdl_pf [1:2];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic idle_all();
    if1.pc = '0; if1.id_rs1 = '0; if1.id_rs2 = '0; if1.id_rs1_re = 0; if1.id_rs2_re = 0;
    if1.id_jump = 0; if1.id_jump_tgt = '0; if1.ex_rd = '0; if1.ex_mem_read = 0;
    if1.ex_br_taken = 0; if1.ex_br_tgt = '0; if1.mem_req = 0; if1.mem_ack = 0;
    if2.pc = '0; if2.id_rs1 = '0; if2.id_rs2 = '0; if2.id_rs1_re = 0; if2.id_rs2_re = 0;
    if2.id_jump = 0; if2.id_jump_tgt = '0; if2.ex_rd = '0; if2.ex_mem_read = 0;
    if2.ex_br_taken = 0; if2.ex_br_tgt = '0; if2.mem_req = 0; if2.mem_ack = 0;
  endtask

  // One clock cycle of stimulus for instance d plus its expected outputs.
  task automatic cyc(input int d, input logic r, input logic [31:0] pc,
                     input logic [4:0] rs1, input logic [4:0] rs2, input logic re1, input logic re2,
                     input logic jmp, input logic [31:0] jt, input logic [4:0] rd, input logic mr,
                     input logic br, input logic [31:0] bt, input logic mq, input logic mk,
                     input logic [31:0] enpc, input logic [3:0] est, input logic [1:0] efl,
                     input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    idle_all();
    if (d == 1) begin
      if1.pc = pc; if1.id_rs1 = rs1; if1.id_rs2 = rs2; if1.id_rs1_re = re1; if1.id_rs2_re = re2;
      if1.id_jump = jmp; if1.id_jump_tgt = jt; if1.ex_rd = rd; if1.ex_mem_read = mr;
      if1.ex_br_taken = br; if1.ex_br_tgt = bt; if1.mem_req = mq; if1.mem_ack = mk;
    end else begin
      if2.pc = pc; if2.id_rs1 = rs1; if2.id_rs2 = rs2; if2.id_rs1_re = re1; if2.id_rs2_re = re2;
      if2.id_jump = jmp; if2.id_jump_tgt = jt; if2.ex_rd = rd; if2.ex_mem_read = mr;
      if2.ex_br_taken = br; if2.ex_br_tgt = bt; if2.mem_req = mq; if2.mem_ack = mk;
    end
    e.d = d; e.r = r; e.npc = enpc; e.st = est; e.fl = efl; e.name = nm;
    exp_q.push_back(e);
  endtask

  // Monitor: pops one expectation per cycle and compares the addressed instance.
  exp_t        m_e;
  logic [31:0] g_npc, g_ps, g_pf;
  logic [3:0]  g_st;
  logic [1:0]  g_fl;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      m_e = exp_q.pop_front();
      if (m_e.d == 1) begin
        g_npc = if1.npc;
        g_st  = {if1.stall_pc, if1.stall_if_id, if1.stall_id_ex, if1.stall_ex_mem};
        g_fl  = {if1.flush_if_id, if1.flush_id_ex};
        g_ps  = if1.perf_stall;
        g_pf  = if1.perf_flush;
      end else begin
        g_npc = if2.npc;
        g_st  = {if2.stall_pc, if2.stall_if_id, if2.stall_id_ex, if2.stall_ex_mem};
        g_fl  = {if2.flush_if_id, if2.flush_id_ex};
        g_ps  = if2.perf_stall;
        g_pf  = if2.perf_flush;
      end
      chk({m_e.name, ".npc"},   g_npc, m_e.npc);
      chk({m_e.name, ".stall"}, {28'h0, g_st}, {28'h0, m_e.st});
      chk({m_e.name, ".flush"}, {30'h0, g_fl}, {30'h0, m_e.fl});
      chk({m_e.name, ".perf"},  {g_ps[15:0], g_pf[15:0]},
          {mdl_ps[m_e.d][15:0], mdl_pf[m_e.d][15:0]});
      if (!m_e.r) begin
        mdl_ps[1] = '0; mdl_ps[2] = '0; mdl_pf[1] = '0; mdl_pf[2] = '0;
      end else begin
`ifdef PIPE_CTRL_PERF_EN
        mdl_ps[m_e.d] = mdl_ps[m_e.d] + {31'h0, m_e.st[3]};
        mdl_pf[m_e.d] = mdl_pf[m_e.d] + {31'h0, m_e.fl[1]};
`endif
      end
    end
  end

  localparam logic [31:0] M4 = 32'hFFFF_FFFC;

  initial begin
    mdl_ps[1] = '0; mdl_ps[2] = '0; mdl_pf[1] = '0; mdl_pf[2] = '0;
    rst = 1'b0;
    idle_all();
    //  d r  pc      rs1 rs2 re1 re2 jmp jt        rd mr br bt        mq mk  npc       st       fl     name
    cyc(1, 0, M4,     0, 0, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 32'h0,   4'b0000, 2'b11, "rst_a");
    cyc(1, 0, M4,     0, 0, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 32'h0,   4'b0000, 2'b11, "rst_b");
    cyc(1, 0, M4,     5, 1, 1, 1, 1, 32'h40,  5, 1, 1, 32'h80,  1, 0, 32'h0,   4'b0000, 2'b11, "rst_ovr");
    cyc(1, 1, M4,     0, 0, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 32'h0,   4'b0000, 2'b00, "wrap");
    cyc(1, 1, 32'h0,  0, 0, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 32'h4,   4'b0000, 2'b00, "seq4");
    cyc(1, 1, 32'h4,  0, 0, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 32'h8,   4'b0000, 2'b00, "seq8");
    cyc(1, 1, 32'h8,  0, 0, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 32'hC,   4'b0000, 2'b00, "seq12");
    cyc(1, 1, 32'hC,  5, 1, 1, 1, 0, 32'h0,   5, 1, 0, 32'h0,   0, 0, 32'hC,   4'b1100, 2'b01, "lu1");
    cyc(1, 1, 32'hC,  5, 1, 1, 1, 0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 32'h10,  4'b0000, 2'b00, "lu1_end");
    cyc(1, 1, 32'h10, 0, 1, 1, 0, 0, 32'h0,   0, 1, 0, 32'h0,   0, 0, 32'h14,  4'b0000, 2'b00, "rd0");
    cyc(1, 1, 32'h14, 3, 7, 1, 1, 0, 32'h0,   7, 1, 0, 32'h0,   0, 0, 32'h14,  4'b1100, 2'b01, "lu_rs2");
    cyc(1, 1, 32'h14, 3, 7, 1, 0, 0, 32'h0,   7, 1, 0, 32'h0,   0, 0, 32'h18,  4'b0000, 2'b00, "re0");
    cyc(1, 1, 32'h18, 5, 1, 1, 1, 0, 32'h0,   5, 1, 1, 32'h100, 0, 0, 32'h100, 4'b0000, 2'b11, "br_hz");
    cyc(1, 1, 32'h100,0, 0, 0, 0, 1, 32'h200, 0, 0, 0, 32'h0,   0, 0, 32'h200, 4'b0000, 2'b10, "jump");
    cyc(1, 1, 32'h200,5, 1, 1, 1, 1, 32'h300, 5, 1, 0, 32'h0,   0, 0, 32'h200, 4'b1100, 2'b01, "jmp_hz");
    cyc(1, 1, 32'h200,5, 1, 1, 1, 1, 32'h300, 0, 0, 0, 32'h0,   0, 0, 32'h300, 4'b0000, 2'b10, "jmp_go");
    cyc(1, 1, 32'h300,0, 0, 0, 0, 1, 32'h403, 0, 0, 0, 32'h0,   0, 0, 32'h400, 4'b0000, 2'b10, "align");
    cyc(1, 1, 32'h400,0, 0, 0, 0, 0, 32'h0,   0, 0, 1, 32'h500, 1, 0, 32'h400, 4'b1111, 2'b00, "mw1");
    cyc(1, 1, 32'h400,0, 0, 0, 0, 0, 32'h0,   0, 0, 1, 32'h500, 1, 0, 32'h400, 4'b1111, 2'b00, "mw2");
    cyc(1, 1, 32'h400,0, 0, 0, 0, 0, 32'h0,   0, 0, 1, 32'h500, 1, 0, 32'h400, 4'b1111, 2'b00, "mw3");
    cyc(1, 1, 32'h400,0, 0, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,   1, 1, 32'h404, 4'b0000, 2'b00, "mw_ack");
    cyc(1, 1, 32'h404,0, 0, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,   0, 1, 32'h408, 4'b0000, 2'b00, "ack_noreq");
    cyc(1, 1, 32'h408,5, 1, 1, 1, 0, 32'h0,   5, 1, 0, 32'h0,   1, 0, 32'h408, 4'b1111, 2'b00, "mw_hz");
    cyc(1, 1, 32'h408,5, 1, 1, 1, 0, 32'h0,   5, 1, 0, 32'h0,   1, 1, 32'h408, 4'b1100, 2'b01, "mwack_hz");
    cyc(1, 1, 32'h408,0, 0, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 32'h40C, 4'b0000, 2'b00, "idle1");
    // LU_CYCLES=2 instance
    cyc(2, 1, 32'h40, 5, 1, 1, 1, 0, 32'h0,   5, 1, 0, 32'h0,   0, 0, 32'h40,  4'b1100, 2'b01, "lu2_c1");
    cyc(2, 1, 32'h40, 5, 1, 1, 1, 0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 32'h40,  4'b1100, 2'b01, "lu2_c2");
    cyc(2, 1, 32'h40, 5, 1, 1, 1, 0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 32'h44,  4'b0000, 2'b00, "lu2_end");
    cyc(2, 1, 32'h44, 5, 1, 1, 1, 0, 32'h0,   5, 1, 0, 32'h0,   0, 0, 32'h44,  4'b1100, 2'b01, "lu2b_c1");
    cyc(2, 1, 32'h44, 5, 1, 1, 1, 0, 32'h0,   0, 0, 0, 32'h0,   1, 0, 32'h44,  4'b1111, 2'b00, "lu2b_mw");
    cyc(2, 1, 32'h44, 5, 1, 1, 1, 0, 32'h0,   0, 0, 0, 32'h0,   1, 1, 32'h44,  4'b1100, 2'b01, "lu2b_res");
    cyc(2, 1, 32'h44, 0, 0, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 32'h48,  4'b0000, 2'b00, "lu2b_end");
    cyc(2, 1, 32'h48, 5, 1, 1, 1, 0, 32'h0,   5, 1, 0, 32'h0,   0, 0, 32'h48,  4'b1100, 2'b01, "lu2c_c1");
    cyc(2, 0, 32'h48, 0, 0, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 32'h0,   4'b0000, 2'b11, "lu2_rst");
    cyc(2, 1, M4,     0, 0, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 32'h0,   4'b0000, 2'b00, "lu2_abort");
    cyc(2, 1, 32'h0,  0, 0, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 32'h4,   4'b0000, 2'b00, "lu2_run");
    // Reset while waiting on data memory
    cyc(1, 1, 32'h0,  0, 0, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,   1, 0, 32'h0,   4'b1111, 2'b00, "mw_r1");
    cyc(1, 0, 32'h0,  0, 0, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,   1, 0, 32'h0,   4'b0000, 2'b11, "mw_rst");
    cyc(1, 1, M4,     0, 0, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 32'h0,   4'b0000, 2'b00, "mw_after");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
